// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: definitions shared by the memory port arbiter and its picker.
//   - arb_state_e : arbiter FSM states
//   - REQ_CPU / REQ_LDR : requester indices (core = 0, loader/DMA = 1)
//   - RR_LAST_RST : reset value of the round-robin history, so the core
//                   wins the first conflict
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GNT0  = 3'd1,
    GNT1  = 3'd2,
    RESP0 = 3'd3,
    RESP1 = 3'd4
  } arb_state_e;

  localparam logic REQ_CPU     = 1'b0;
  localparam logic REQ_LDR     = 1'b1;
  localparam logic RR_LAST_RST = REQ_LDR;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick: combinational two-way winner selection.
//   req[1:0]   : pending requests (bit x = requester x)
//   rr_last    : requester served most recently
//   lock_valid : a lock is held
//   lock_owner : requester holding the lock
//   winner     : selected requester; meaningful only when the caller has
//                established that the selection yields a grant
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_last,
  input  logic       lock_valid,
  input  logic       lock_owner,
  output logic       winner
);

  // Lock owner first, then the requester not served last on a conflict.
  always_comb begin
    winner = REQ_CPU;
    if (lock_valid) begin
      winner = lock_owner;
    end else if (req == 2'b11) begin
      winner = ~rr_last;
    end else if (req[1]) begin
      winner = REQ_LDR;
    end else begin
      winner = REQ_CPU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous-read memory port between the
// RV32I core (requester 0) and the loader/DMA engine (requester 1).
//   clk, reset (async, active low)
//   req/we/lock/addr/wdata 0|1 : request payload, held until gnt
//   gnt0|1    : one-cycle grant, the access is on the memory port that cycle
//   rvalid0|1, rdata0|1 : read return, rdata is zero outside rvalid
//   mem_addr/mem_wdata/mem_we -> memory, mem_rdata <- memory (1-cycle read)
//   gnt_cnt0/gnt_cnt1/conflict_cnt : saturating statistics, present only
//   when the macro MEM_ARB_STATS_EN is defined
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1,
  output logic [CNT_W-1:0]  conflict_cnt
`endif
);

  arb_state_e state_r, state_nxt_s;
  logic       rr_last_r, rr_last_nxt_s;
  logic       lock_valid_r, lock_valid_nxt_s;
  logic       lock_owner_r, lock_owner_nxt_s;
  logic [1:0] req_s;
  logic       winner_s;
  logic       grant_s;

  assign req_s = {req1, req0};

  mem_arb_rr_pick u_pick (
    .req        (req_s),
    .rr_last    (rr_last_r),
    .lock_valid (lock_valid_r),
    .lock_owner (lock_owner_r),
    .winner     (winner_s)
  );

  // A held lock admits only its owner; otherwise any request is granted.
  always_comb begin
    grant_s = 1'b0;
    if (lock_valid_r) begin
      grant_s = req_s[lock_owner_r];
    end else begin
      grant_s = |req_s;
    end
  end

  // Next state plus round-robin and lock bookkeeping.
  always_comb begin
    state_nxt_s      = state_r;
    rr_last_nxt_s    = rr_last_r;
    lock_valid_nxt_s = lock_valid_r;
    lock_owner_nxt_s = lock_owner_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_nxt_s = winner_s ? GNT1 : GNT0;
        end else begin
          state_nxt_s = IDLE;
        end
        // Owner went quiet: drop the lock; arbitration reopens next cycle.
        if (lock_valid_r && !req_s[lock_owner_r]) begin
          lock_valid_nxt_s = 1'b0;
        end else begin
          lock_valid_nxt_s = lock_valid_r;
        end
      end
      GNT0: begin
        rr_last_nxt_s = REQ_CPU;
        if (we0) begin
          state_nxt_s      = IDLE;
          lock_valid_nxt_s = lock0;
          lock_owner_nxt_s = REQ_CPU;
        end else begin
          state_nxt_s = RESP0;
        end
      end
      GNT1: begin
        rr_last_nxt_s = REQ_LDR;
        if (we1) begin
          state_nxt_s      = IDLE;
          lock_valid_nxt_s = lock1;
          lock_owner_nxt_s = REQ_LDR;
        end else begin
          state_nxt_s = RESP1;
        end
      end
      RESP0: begin
        state_nxt_s      = IDLE;
        lock_valid_nxt_s = lock0;
        lock_owner_nxt_s = REQ_CPU;
      end
      RESP1: begin
        state_nxt_s      = IDLE;
        lock_valid_nxt_s = lock1;
        lock_owner_nxt_s = REQ_LDR;
      end
      default: begin
        state_nxt_s      = IDLE;
        lock_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM, round-robin history and lock registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      rr_last_r    <= RR_LAST_RST;
      lock_valid_r <= 1'b0;
      lock_owner_r <= REQ_CPU;
    end else begin
      state_r      <= state_nxt_s;
      rr_last_r    <= rr_last_nxt_s;
      lock_valid_r <= lock_valid_nxt_s;
      lock_owner_r <= lock_owner_nxt_s;
    end
  end

  // Port steering: the memory port carries the granted payload in GNTx and is
  // zero otherwise, so a reset drops mem_we in the same cycle.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    rdata0    = {DATA_W{1'b0}};
    rdata1    = {DATA_W{1'b0}};
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    mem_we    = 1'b0;
    case (state_r)
      GNT0: begin
        gnt0      = 1'b1;
        mem_addr  = addr0;
        mem_wdata = wdata0;
        mem_we    = we0;
      end
      GNT1: begin
        gnt1      = 1'b1;
        mem_addr  = addr1;
        mem_wdata = wdata1;
        mem_we    = we1;
      end
      RESP0: begin
        rvalid0 = 1'b1;
        rdata0  = mem_rdata;
      end
      RESP1: begin
        rvalid1 = 1'b1;
        rdata1  = mem_rdata;
      end
      default: begin
        gnt0 = 1'b0;
      end
    endcase
  end

`ifdef MEM_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating grant and conflict counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_cnt0     <= {CNT_W{1'b0}};
      gnt_cnt1     <= {CNT_W{1'b0}};
      conflict_cnt <= {CNT_W{1'b0}};
    end else begin
      if ((state_r == GNT0) && (gnt_cnt0 != CNT_MAX)) begin
        gnt_cnt0 <= gnt_cnt0 + CNT_ONE;
      end
      if ((state_r == GNT1) && (gnt_cnt1 != CNT_MAX)) begin
        gnt_cnt1 <= gnt_cnt1 + CNT_ONE;
      end
      if ((state_r == IDLE) && req0 && req1 && (conflict_cnt != CNT_MAX)) begin
        conflict_cnt <= conflict_cnt + CNT_ONE;
      end
    end
  end
`else
  logic unused_cnt_w_s;
  assign unused_cnt_w_s = ^CNT_W;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic        lock0 = 1'b0, lock1 = 1'b0;
  logic [31:0] addr0 = 32'h0, addr1 = 32'h0, wdata0 = 32'h0, wdata1 = 32'h0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  localparam int NC = 600;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .conflict_cnt(conflict_cnt)
`endif
  );

  // Power-on / reset content of the memory model; word 64 is byte 0x100.
  function automatic logic [31:0] mem_init(input int i);
    logic [31:0] v;
    if (i == 64) v = 32'hDEADBEEF;
    else v = (32'(i) * 32'h0001_0203) ^ 32'h5A5A_0000;
    return v;
  endfunction

  // Synchronous-read memory, 128 words, reloaded while reset is low.
  logic [31:0] mem [0:127];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) mem[i] <= mem_init(i);
      mem_rdata <= 32'h0;
    end else begin
      if (mem_we) mem[mem_addr[8:2]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[8:2]];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(posedge clk);
    sample();
    checks++;
    if ({gnt1, gnt0, rvalid1, rvalid0, mem_we} !== 5'b0)
      $display("FAIL reset_strobes: got %b expected 00000", {gnt1, gnt0, rvalid1, rvalid0, mem_we});
    checks++;
    if ({mem_addr, mem_wdata} !== 64'h0)
      $display("FAIL reset_mem_port: got %h expected 0", {mem_addr, mem_wdata});
    checks++;
    if ({rdata0, rdata1} !== 64'h0)
      $display("FAIL reset_rdata: got %h expected 0", {rdata0, rdata1});
`ifdef MEM_ARB_STATS_EN
    checks++;
    if ({gnt_cnt0, gnt_cnt1, conflict_cnt} !== 48'h0)
      $display("FAIL reset_counters: got %h expected 0", {gnt_cnt0, gnt_cnt1, conflict_cnt});
`endif
    errors += (({gnt1, gnt0, rvalid1, rvalid0, mem_we} !== 5'b0) ? 1 : 0)
            + (({mem_addr, mem_wdata} !== 64'h0) ? 1 : 0)
            + (({rdata0, rdata1} !== 64'h0) ? 1 : 0);
`ifdef MEM_ARB_STATS_EN
    errors += ({gnt_cnt0, gnt_cnt1, conflict_cnt} !== 48'h0) ? 1 : 0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    next_cycle();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
    sample();
    checks++;
    if ({gnt1, gnt0} !== 2'b00) begin errors++; $display("FAIL read_no_early_gnt: got %b expected 00", {gnt1, gnt0}); end
    next_cycle();
    sample();
    checks++;
    if ({gnt1, gnt0} !== 2'b01) begin errors++; $display("FAIL read_gnt0: got %b expected 01", {gnt1, gnt0}); end
    checks++;
    if ({mem_we, mem_addr} !== {1'b0, 32'h100}) begin errors++; $display("FAIL read_mem_port: got %b/%h expected 0/00000100", mem_we, mem_addr); end
    next_cycle();
    req0 = 1'b0; addr0 = 32'h0;
    sample();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data: got %b/%h expected 1/deadbeef", rvalid0, rdata0); end
    next_cycle();
    sample();
    checks++;
    if ({rvalid0, rdata0} !== 33'h0) begin errors++; $display("FAIL read_idle_after: got %b/%h expected 0/0", rvalid0, rdata0); end
  endtask

  task automatic test_simultaneous_writes();
    logic [1:0]  exp;
    logic [31:0] ea;
    do_reset();
    next_cycle();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 32'h10; addr1 = 32'h20; wdata0 = 32'h1111_0000; wdata1 = 32'h2222_0000;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) next_cycle();
      sample();
      exp = (c == 1 || c == 5) ? 2'b01 : ((c == 3 || c == 7) ? 2'b10 : 2'b00);
      checks++;
      if ({gnt1, gnt0} !== exp) begin errors++; $display("FAIL conflict_gnt c%0d: got %b expected %b", c, {gnt1, gnt0}, exp); end
      if (exp != 2'b00) begin
        ea = exp[0] ? 32'h10 : 32'h20;
        checks++;
        if ({mem_we, mem_addr} !== {1'b1, ea}) begin errors++; $display("FAIL conflict_port c%0d: got %b/%h expected 1/%h", c, mem_we, mem_addr, ea); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_lock_burst();
    logic [1:0] exp;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      next_cycle();
      if (c == 0) begin req1 = 1'b1; we1 = 1'b1; lock1 = 1'b1; addr1 = 32'h40; wdata1 = 32'h0; end
      if (c == 1) begin req0 = 1'b1; we0 = 1'b1; addr0 = 32'h50; wdata0 = 32'hC0C0; end
      if (c == 2 || c == 4 || c == 6) begin wdata1 = 32'(c); lock1 = (c != 6); end
      if (c == 8) begin req1 = 1'b0; lock1 = 1'b0; end
      if (c == 10) req0 = 1'b0;
      sample();
      exp = (c == 1 || c == 3 || c == 5 || c == 7) ? 2'b10 : ((c == 9) ? 2'b01 : 2'b00);
      checks++;
      if ({gnt1, gnt0} !== exp) begin errors++; $display("FAIL lock_gnt c%0d: got %b expected %b", c, {gnt1, gnt0}, exp); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    next_cycle();
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h30; wdata1 = 32'h55;
    sample();
    next_cycle();
    sample();
    checks++;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_write_pre: mem_we got %b expected 1", mem_we); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_we, gnt1} !== 2'b00) begin errors++; $display("FAIL rst_write_drop: got %b expected 00", {mem_we, gnt1}); end
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    next_cycle();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h100;
    sample();
    next_cycle();
    sample();
    next_cycle();
    req0 = 1'b0;
    sample();
    checks++;
    if (rvalid0 !== 1'b1) begin errors++; $display("FAIL rst_read_pre: rvalid0 got %b expected 1", rvalid0); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({rvalid0, rdata0, mem_we, gnt0, gnt1} !== 36'h0) begin errors++; $display("FAIL rst_read_drop: got %b/%h expected 0/0", rvalid0, rdata0); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    next_cycle();
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h100;
    sample();
    checks++;
    if ({gnt1, gnt0} !== 2'b00) begin errors++; $display("FAIL rst_after_idle: got %b expected 00", {gnt1, gnt0}); end
    next_cycle();
    sample();
    checks++;
    if ({gnt1, gnt0, mem_addr} !== {2'b10, 32'h100}) begin errors++; $display("FAIL rst_after_gnt: got %b/%h expected 10/00000100", {gnt1, gnt0}, mem_addr); end
    next_cycle();
    req1 = 1'b0;
    sample();
    checks++;
    if ({rvalid1, rvalid0, rdata1} !== {2'b10, 32'hDEADBEEF}) begin errors++; $display("FAIL rst_after_data: got %b/%h expected 10/deadbeef", {rvalid1, rvalid0}, rdata1); end
    idle_inputs();
  endtask

`ifdef MEM_ARB_STATS_EN
  task automatic solo_write(input bit who);
    int lat;
    lat = -1;
    next_cycle();
    if (who) begin req1 = 1'b1; we1 = 1'b1; addr1 = 32'h60; end
    else begin req0 = 1'b1; we0 = 1'b1; addr0 = 32'h64; end
    for (int i = 0; i < 4 && lat < 0; i++) begin
      sample();
      if (who ? gnt1 : gnt0) lat = i;
      else next_cycle();
    end
    checks++;
    if (lat != 1) begin errors++; $display("FAIL solo_write_latency req%0d: got %0d expected 1", who, lat); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_stats();
    do_reset();
    next_cycle();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1; addr0 = 32'h68; addr1 = 32'h6C;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) next_cycle();
      if (c == 6) req0 = 1'b0;
      sample();
    end
    next_cycle();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      solo_write(1'b0);
      solo_write(1'b1);
    end
    sample();
    checks++;
    if ({gnt_cnt0, gnt_cnt1} !== {16'd5, 16'd5}) begin errors++; $display("FAIL stats_gnt: got %0d/%0d expected 5/5", gnt_cnt0, gnt_cnt1); end
    checks++;
    if (conflict_cnt !== 16'd3) begin errors++; $display("FAIL stats_conflict: got %0d expected 3", conflict_cnt); end
  endtask
`endif

  // Randomised traffic against a transaction-schedule model: whenever the
  // port is free the model picks a winner and books the grant, the read
  // return and the point where the lock input is sampled.
  task automatic test_random();
    logic [1:0]  e_gnt [0:NC+3];
    logic [1:0]  e_rv  [0:NC+3];
    logic        e_we  [0:NC+3];
    logic [31:0] e_addr[0:NC+3];
    logic [31:0] e_wd  [0:NC+3];
    logic [31:0] e_rd  [0:NC+3];
    logic [31:0] ref_mem [0:127];
    int          ph [2];
    logic        a_we [2];
    logic        a_lock [2];
    logic [31:0] a_addr [2];
    logic [31:0] a_wd [2];
    int          free_at, lock_at;
    logic        lock_on, lock_who, last_served, lock_from, w, has;
    logic [31:0] er0, er1;

    do_reset();
    for (int i = 0; i < 128; i++) ref_mem[i] = mem_init(i);
    for (int i = 0; i < NC + 4; i++) begin
      e_gnt[i] = 2'b00; e_rv[i] = 2'b00; e_we[i] = 1'b0;
      e_addr[i] = 32'h0; e_wd[i] = 32'h0; e_rd[i] = 32'h0;
    end
    for (int x = 0; x < 2; x++) begin
      ph[x] = 0; a_we[x] = 1'b0; a_lock[x] = 1'b0; a_addr[x] = 32'h0; a_wd[x] = 32'h0;
    end
    free_at = 0; lock_at = -1; lock_on = 1'b0; lock_who = 1'b0;
    last_served = 1'b1; lock_from = 1'b0;

    for (int c = 0; c < NC; c++) begin
      next_cycle();
      for (int x = 0; x < 2; x++) begin
        if (c > 0 && ph[x] == 1 && e_gnt[c-1][x]) ph[x] = a_we[x] ? 0 : 2;
        else if (c > 0 && ph[x] == 2 && e_rv[c-1][x]) ph[x] = 0;
        if (ph[x] == 0 && $urandom_range(0, 1) == 1) begin
          ph[x]     = 1;
          a_we[x]   = 1'($urandom_range(0, 1));
          a_addr[x] = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
          a_wd[x]   = $urandom;
          a_lock[x] = ($urandom_range(0, 2) == 0);
        end
      end
      req0 = (ph[0] == 1); we0 = a_we[0]; addr0 = a_addr[0]; wdata0 = a_wd[0];
      lock0 = (ph[0] != 0) && a_lock[0];
      req1 = (ph[1] == 1); we1 = a_we[1]; addr1 = a_addr[1]; wdata1 = a_wd[1];
      lock1 = (ph[1] != 0) && a_lock[1];

      if (c == lock_at) begin
        lock_on  = lock_from ? lock1 : lock0;
        lock_who = lock_from;
      end
      if (c >= free_at) begin
        has = 1'b0; w = 1'b0;
        if (lock_on) begin
          if ((lock_who ? req1 : req0)) begin w = lock_who; has = 1'b1; end
          else lock_on = 1'b0;
        end else if (req0 && req1) begin
          w = ~last_served; has = 1'b1;
        end else if (req0 || req1) begin
          w = req1; has = 1'b1;
        end
        if (has) begin
          e_gnt[c+1][w] = 1'b1;
          e_we[c+1]     = a_we[w];
          e_addr[c+1]   = a_addr[w];
          e_wd[c+1]     = a_wd[w];
          if (a_we[w]) begin
            ref_mem[a_addr[w][8:2]] = a_wd[w];
            free_at = c + 2; lock_at = c + 1;
          end else begin
            e_rv[c+2][w] = 1'b1;
            e_rd[c+2]    = ref_mem[a_addr[w][8:2]];
            free_at = c + 3; lock_at = c + 2;
          end
          lock_from = w; last_served = w;
        end
      end

      sample();
      er0 = e_rv[c][0] ? e_rd[c] : 32'h0;
      er1 = e_rv[c][1] ? e_rd[c] : 32'h0;
      checks++;
      if ({gnt1, gnt0} !== e_gnt[c]) begin errors++; $display("FAIL rand_gnt c%0d: got %b expected %b", c, {gnt1, gnt0}, e_gnt[c]); end
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== {e_we[c], e_addr[c], e_wd[c]}) begin
        errors++; $display("FAIL rand_port c%0d: got %b/%h/%h expected %b/%h/%h", c, mem_we, mem_addr, mem_wdata, e_we[c], e_addr[c], e_wd[c]);
      end
      checks++;
      if ({rvalid1, rvalid0} !== e_rv[c]) begin errors++; $display("FAIL rand_rvalid c%0d: got %b expected %b", c, {rvalid1, rvalid0}, e_rv[c]); end
      checks++;
      if ({rdata0, rdata1} !== {er0, er1}) begin errors++; $display("FAIL rand_rdata c%0d: got %h/%h expected %h/%h", c, rdata0, rdata1, er0, er1); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous_writes();
    test_lock_burst();
    test_reset_mid_access();
`ifdef MEM_ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
